store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered store entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets; deassertion synchronous to clk).
REQ-004 SHALL have port cpu_wr  input  1  CPU store request.
REQ-005 SHALL have port cpu_rd  input  1  CPU load request.
REQ-006 SHALL have port cpu_addr  input  32  CPU load/store address.
REQ-007 SHALL have port cpu_wdata  input  32  CPU store data.
REQ-008 SHALL have port cpu_rdata  output  32  load data, registered.
REQ-009 SHALL have port stall  output  1  request not accepted this cycle; CPU holds request.
REQ-010 SHALL have port mem_wr  output  1  data-memory write enable.
REQ-011 SHALL have port mem_addr  output  32  data-memory address.
REQ-012 SHALL have port mem_write_data  output  32  data-memory write data.
REQ-013 SHALL have port mem_read_data  input  32  data-memory read data, valid one cycle after mem_addr presented (syncram timing).

Function
REQ-014 SHALL hold stores in a circular FIFO of DEPTH {addr,data} entries with write pointer, read pointer and count (0..DEPTH).
REQ-015 SHALL accept cpu_wr when count<DEPTH: entry written at write pointer, pointer wraps DEPTH-1 -> 0, stall=0.
REQ-016 SHALL assert stall combinationally when cpu_wr and count==DEPTH; no entry written, even if a drain occurs that cycle.
REQ-017 SHALL, when cpu_wr and cpu_rd are both 1, accept only the store; load ignored, cpu_rdata unchanged, stall follows REQ-016 only.
REQ-018 SHALL serve an accepted load (cpu_rd=1, stall=0) by driving mem_addr=cpu_addr, mem_wr=0 that cycle; cpu_rdata=mem_read_data registered at end of next cycle (load latency 1 cycle after acceptance).
REQ-019 SHALL drain the oldest entry (mem_wr=1, mem_addr/mem_write_data from read pointer, pointer wraps, count-1) in any cycle the memory port is not used by a load and count>0.
REQ-020 SHALL, on simultaneous accept and drain, leave count unchanged.
REQ-021 SHALL treat a load hazard as cpu_rd with cpu_addr equal (full 32-bit compare) to any valid entry; handling per Configuration.
REQ-022 SHALL drive mem_wr=0, mem_addr=0, mem_write_data=0 when neither load nor drain occurs.
REQ-023 SHALL never reorder stores; memory sees stores in acceptance order, each exactly once.

Reset
REQ-024 SHALL on reset=0 immediately clear count, both pointers, cpu_rdata=0, mem_wr=0; stall=0.
REQ-025 SHALL discard all pending entries on reset mid-operation; no further writes to memory from those entries.
REQ-026 SHALL abort an in-flight load on reset; cpu_rdata stays 0.

Configuration
REQ-027 SHALL compile store-to-load forwarding when macro STORE_BUFFER_FWD_EN is defined: hazard load accepted (stall=0), no memory read, cpu_rdata=data of youngest matching entry one cycle later; memory port free for drain.
REQ-028 SHALL without STORE_BUFFER_FWD_EN stall a hazard load (stall=1) while draining continues, accepting it the first cycle no match remains.

Verification
REQ-029 Reset: reset=0 mid-drain with count=3 -> count=0, mem_wr=0 immediately, none of remaining 3 stores reach memory.
REQ-030 Fill: 5 back-to-back stores with cpu_rd=1 held at unrelated address 0x100 (DEPTH=4) -> 5th store sees stall=1 until a load cycle ends; after cpu_rd=0, drain writes addr 0,4,8,12,16 in order.
REQ-031 Drain wrap: 10 stores to 0x40..0x64 interleaved with idle cycles -> memory contents match in order, pointers wrap cleanly, count returns to 0.
REQ-032 Hazard, FWD_EN: store 0xDEADBEEF to 0x20, store 0x12345678 to 0x20, load 0x20 next cycle -> stall=0, cpu_rdata=0x12345678 one cycle later.
REQ-033 Hazard, no FWD_EN: same stimulus -> stall=1 until both stores drained, then cpu_rdata=0x12345678 from memory.
REQ-034 Simultaneous: count=DEPTH, cpu_wr=1, drain active -> stall=1, count becomes DEPTH-1; next cycle store accepted, count=DEPTH.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending CPU stores draining to a syncram port, loads take priority.
// Define STORE_BUFFER_FWD_EN to forward the youngest matching store to a load instead of stalling it.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ld_pend;

    logic          w_full;
    logic          w_hit;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_mem_rd;
    logic          w_drain;
    logic [AW-1:0] w_idx;
`ifdef STORE_BUFFER_FWD_EN
    logic [31:0]   w_hit_data;
    logic          r_ld_fwd;
    logic [31:0]   r_fwd_data;
`endif

    assign w_full = (r_count == CW'(DEPTH));

    // Scan valid entries oldest to youngest so the last match is the youngest store.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
`ifdef STORE_BUFFER_FWD_EN
        w_hit_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + AW'(i);
            if (cpu_rd && (CW'(i) < r_count) && (r_addr[w_idx] == cpu_addr)) begin
                w_hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                w_hit_data = r_data[w_idx];
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign stall = cpu_wr & w_full;
`else
    assign stall = cpu_wr ? w_full : (cpu_rd & w_hit);
`endif

    assign w_wr_acc = cpu_wr & ~w_full;
    assign w_rd_acc = cpu_rd & ~cpu_wr & ~stall;
    // A non-hazard read occupies the port even when a concurrent store makes the CPU ignore its data.
    assign w_mem_rd = cpu_rd & ~w_hit;
    assign w_drain  = ~w_mem_rd & (r_count != '0);

    always_comb begin
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (w_mem_rd) begin
            mem_addr = cpu_addr;
        end else if (w_drain) begin
            mem_wr         = 1'b1;
            mem_addr       = r_addr[r_rptr];
            mem_write_data = r_data[r_rptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ld_pend <= 1'b0;
            cpu_rdata <= '0;
`ifdef STORE_BUFFER_FWD_EN
            r_ld_fwd   <= 1'b0;
            r_fwd_data <= '0;
`endif
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_drain) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr_acc, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_ld_pend <= w_rd_acc;
`ifdef STORE_BUFFER_FWD_EN
            r_ld_fwd   <= w_rd_acc & w_hit;
            r_fwd_data <= w_hit_data;
            if (r_ld_pend) begin
                cpu_rdata <= r_ld_fwd ? r_fwd_data : mem_read_data;
            end
`else
            if (r_ld_pend) begin
                cpu_rdata <= mem_read_data;
            end
`endif
        end
    end

    // Entry storage needs no reset; validity is carried by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_addr[r_wptr] <= cpu_addr;
            r_data[r_wptr] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a syncram memory model and a write log.
// Hazard expectations follow STORE_BUFFER_FWD_EN when the bench is built with it.
module tb_store_buffer;
    logic        clk;
    logic        reset;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [31:0]];
    logic [63:0] wlog [$];
    logic [31:0] mem_q;

    store_buffer #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_wr         (cpu_wr),
        .cpu_rd         (cpu_rd),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .stall          (stall),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Syncram: writes land at the edge, read data appears one cycle after the address.
    always @(posedge clk) begin
        mem_q <= mem.exists(mem_addr) ? mem[mem_addr] : ~mem_addr;
        if (mem_wr) begin
            mem[mem_addr] = mem_write_data;
            wlog.push_back({mem_addr, mem_write_data});
        end
    end
    assign mem_read_data = mem_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu_wr    = wr;
        cpu_rd    = rd;
        cpu_addr  = a;
        cpu_wdata = d;
        #1;
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
        logic [63:0] e;
        if (idx < wlog.size()) e = wlog[idx];
        else e = '1;
        chk({tag, "_addr"}, e[63:32], ea);
        chk({tag, "_data"}, e[31:0], ed);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fill: loads held high keep the port busy so nothing drains
        drive(1'b0, 1'b1, 32'h100, 32'h0);
        chk("ld_stall", {31'b0, stall}, 32'd0);
        chk("ld_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("ld_mem_addr", mem_addr, 32'h100);
        drive(1'b1, 1'b1, 32'h0, 32'h1111_0000);
        chk("fill0_stall", {31'b0, stall}, 32'd0);
        chk("fill0_mem_wr", {31'b0, mem_wr}, 32'd0);
        drive(1'b1, 1'b1, 32'h4, 32'h1111_0004);
        chk("ld_rdata", cpu_rdata, 32'hFFFF_FEFF);
        drive(1'b1, 1'b1, 32'h8, 32'h1111_0008);
        chk("ld_ignored_rdata", cpu_rdata, 32'hFFFF_FEFF);
        drive(1'b1, 1'b1, 32'hC, 32'h1111_000C);
        chk("fill3_stall", {31'b0, stall}, 32'd0);
        drive(1'b1, 1'b1, 32'h10, 32'h1111_0010);
        chk("full_stall_a", {31'b0, stall}, 32'd1);
        chk("full_mem_wr", {31'b0, mem_wr}, 32'd0);
        drive(1'b1, 1'b1, 32'h10, 32'h1111_0010);
        chk("full_stall_b", {31'b0, stall}, 32'd1);
        drive(1'b1, 1'b0, 32'h10, 32'h1111_0010);
        chk("full_drain_stall", {31'b0, stall}, 32'd1);
        chk("full_drain_wr", {31'b0, mem_wr}, 32'd1);
        chk("full_drain_addr", mem_addr, 32'h0);
        chk("full_drain_data", mem_write_data, 32'h1111_0000);
        drive(1'b1, 1'b0, 32'h10, 32'h1111_0010);
        chk("fifth_accept", {31'b0, stall}, 32'd0);
        chk("fifth_drain_addr", mem_addr, 32'h4);
        repeat (3) drive(1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("fill_idle_wr", {31'b0, mem_wr}, 32'd0);
        chk("fill_idle_addr", mem_addr, 32'd0);
        chk("fill_log_n", wlog.size(), 32'd5);
        for (int i = 0; i < 5; i++) chk_log("fill_log", i, 32'(4 * i), 32'h1111_0000 + 32'(4 * i));

        // Full + simultaneous drain, then reset in the middle of draining
        wlog.delete();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'h2222_0000 + 32'(4 * i));
        chk("b_fill_stall", {31'b0, stall}, 32'd0);
        drive(1'b1, 1'b0, 32'h210, 32'h2222_0010);
        chk("sim_stall", {31'b0, stall}, 32'd1);
        chk("sim_drain_wr", {31'b0, mem_wr}, 32'd1);
        chk("sim_drain_addr", mem_addr, 32'h200);
        drive(1'b1, 1'b1, 32'h210, 32'h2222_0010);
        chk("sim_next_accept", {31'b0, stall}, 32'd0);
        chk("sim_next_wr", {31'b0, mem_wr}, 32'd0);
        drive(1'b1, 1'b1, 32'h214, 32'h2222_0014);
        chk("sim_full_again", {31'b0, stall}, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("b_drain1_addr", mem_addr, 32'h204);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("b_drain2_wr", {31'b0, mem_wr}, 32'd1);
        chk("b_drain2_addr", mem_addr, 32'h208);
        #2 reset = 1'b0;
        #1;
        chk("midrst_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("midrst_stall", {31'b0, stall}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("postrst_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("midrst_log_n", wlog.size(), 32'd2);
        chk_log("midrst_log", 1, 32'h204, 32'h2222_0004);

        // Drain wrap: ten stores separated by idle cycles
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h3333_0000 + 32'(i));
            chk("wrap_stall", {31'b0, stall}, 32'd0);
            drive(1'b0, 1'b0, 32'h0, 32'h0);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_empty_wr", {31'b0, mem_wr}, 32'd0);
        chk("wrap_log_n", wlog.size(), 32'd10);
        for (int i = 0; i < 10; i++) chk_log("wrap_log", i, 32'h40 + 32'(4 * i), 32'h3333_0000 + 32'(i));

        // Load hazard on 0x20
        wlog.delete();
        drive(1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF);
        chk("hz_st1_stall", {31'b0, stall}, 32'd0);
        drive(1'b1, 1'b0, 32'h20, 32'h1234_5678);
        chk("hz_st2_stall", {31'b0, stall}, 32'd0);
        chk("hz_st2_drain", mem_write_data, 32'hDEAD_BEEF);
        drive(1'b0, 1'b1, 32'h20, 32'h0);
`ifdef STORE_BUFFER_FWD_EN
        chk("hz_ld_stall", {31'b0, stall}, 32'd0);
`else
        chk("hz_ld_stall", {31'b0, stall}, 32'd1);
`endif
        chk("hz_ld_drain_wr", {31'b0, mem_wr}, 32'd1);
        chk("hz_ld_drain_data", mem_write_data, 32'h1234_5678);
        drive(1'b0, 1'b1, 32'h20, 32'h0);
        chk("hz_clear_stall", {31'b0, stall}, 32'd0);
        chk("hz_clear_wr", {31'b0, mem_wr}, 32'd0);
        chk("hz_clear_addr", mem_addr, 32'h20);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("hz_rdata", cpu_rdata, 32'h1234_5678);
        chk("hz_log_n", wlog.size(), 32'd2);

        // Reset aborts an in-flight load
        drive(1'b0, 1'b1, 32'h300, 32'h0);
        chk("abort_ld_addr", mem_addr, 32'h300);
        @(negedge clk);
        cpu_rd = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("abort_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("abort_rdata_hold", cpu_rdata, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
